// File: rtl/bankr_pkg.sv
// Shared types and constants for the register-bank write-port arbiter.
// Imported by the round-robin arbiter and the top level.
package bankr_pkg;

  localparam int DIRW_DEF  = 5;
  localparam int DATAW_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
// The served-last pointer moves only when the caller reports an actual accept.
module rr_arb2
  import bankr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  grant_e last;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == GNT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= GNT_B;
    end else if (adv && (gnt != 2'b00)) begin
      last <= gnt[0] ? GNT_A : GNT_B;
    end
  end

endmodule

// File: rtl/bankr_wr_arbiter.sv
// Shares the register-bank write port between ALU (A) and load (B) writeback
// through a one-entry holding register, and flags RAW hazards on decode reads.
module bankr_wr_arbiter
  import bankr_pkg::*;
#(
  parameter int DIRW      = DIRW_DEF,
  parameter int DATAW     = DATAW_DEF,
  parameter int ZERO_DROP = 1,
  parameter int CNTW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [DIRW-1:0]  a_dir,
  input  logic [DATAW-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [DIRW-1:0]  b_dir,
  input  logic [DATAW-1:0] b_data,
  input  logic             stall,
  input  logic [DIRW-1:0]  Rd1,
  input  logic [DIRW-1:0]  Rd2,
  output logic             hazard1,
  output logic             hazard2,
  output logic             Rw,
  output logic [DIRW-1:0]  Dir,
  output logic [DATAW-1:0] DIn,
  output logic [CNTW-1:0]  wr_count
);

  localparam logic [DIRW-1:0] ZERO_DIR = DIRW'(REG_ZERO);
  localparam bit              DROP     = (ZERO_DROP != 0);

  hold_state_e      state;
  logic [DIRW-1:0]  hold_dir;
  logic [DATAW-1:0] hold_data;
  logic             full;
  logic             drain;
  logic             accept;
  logic             take;
  logic [1:0]       gnt;

  assign full   = (state == FULL);
  assign drain  = full && !stall;
  // A new entry can enter whenever the slot is free or is leaving this cycle.
  assign accept = !full || drain;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_valid, a_valid}),
    .adv   (accept),
    .gnt   (gnt)
  );

  assign a_ready = accept && gnt[0];
  assign b_ready = accept && gnt[1];
  assign take    = a_ready || b_ready;

  // NOTE: the hold register is a plain flop pair, so it is reset along with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      hold_dir  <= '0;
      hold_data <= '0;
    end else if (take) begin
      state     <= FULL;
      hold_dir  <= a_ready ? a_dir  : b_dir;
      hold_data <= a_ready ? a_data : b_data;
    end else if (drain) begin
      state <= EMPTY;
    end
  end

  // Register 0 entries are consumed like any other but never reach the bank.
  assign Rw  = drain && !(DROP && (hold_dir == ZERO_DIR));
  assign Dir = hold_dir;
  assign DIn = hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (Rw) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  // Held through the draining cycle: the bank only sees the data at the edge.
  assign hazard1 = full && (hold_dir == Rd1) && !(DROP && (Rd1 == ZERO_DIR));
  assign hazard2 = full && (hold_dir == Rd2) && !(DROP && (Rd2 == ZERO_DIR));

endmodule

// File: tb/tb_bankr_wr_arbiter.sv
// Self-checking bench for bankr_wr_arbiter: directed scenarios followed by
// randomized traffic, all scored against a transaction-level reference model.
module tb_bankr_wr_arbiter;
  import bankr_pkg::*;

  localparam int DIRW  = 5;
  localparam int DATAW = 32;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_valid, b_valid, stall;
  logic             a_ready, b_ready;
  logic [DIRW-1:0]  a_dir, b_dir, Rd1, Rd2;
  logic [DATAW-1:0] a_data, b_data;
  logic             hazard1, hazard2, Rw;
  logic [DIRW-1:0]  Dir;
  logic [DATAW-1:0] DIn;
  logic [CNTW-1:0]  wr_count;

  bankr_wr_arbiter #(
    .DIRW(DIRW), .DATAW(DATAW), .ZERO_DROP(1), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_dir(a_dir), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dir(b_dir), .b_data(b_data),
    .stall(stall), .Rd1(Rd1), .Rd2(Rd2),
    .hazard1(hazard1), .hazard2(hazard2),
    .Rw(Rw), .Dir(Dir), .DIn(DIn), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one pending write, who was served last, writes completed.
  bit               m_full;
  logic [DIRW-1:0]  m_dir;
  logic [DATAW-1:0] m_data;
  bit               m_last_b;
  logic [CNTW-1:0]  m_cnt;

  // Outputs sampled in the most recent step, for scenario-specific checks.
  logic             s_ar, s_br, s_rw, s_h1, s_h2;
  logic [DIRW-1:0]  s_dir;
  logic [DATAW-1:0] s_din;
  logic [CNTW-1:0]  s_cnt;

  task automatic model_reset();
    m_full   = 1'b0;
    m_dir    = '0;
    m_data   = '0;
    m_last_b = 1'b1;
    m_cnt    = '0;
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, advance the model.
  task automatic step(input bit av, input logic [DIRW-1:0] ad, input logic [DATAW-1:0] adt,
                      input bit bv, input logic [DIRW-1:0] bd, input logic [DATAW-1:0] bdt,
                      input bit st, input logic [DIRW-1:0] r1, input logic [DIRW-1:0] r2);
    bit drain, room, ga, gb, erw;
    @(negedge clk);
    a_valid = av; a_dir = ad; a_data = adt;
    b_valid = bv; b_dir = bd; b_data = bdt;
    stall = st; Rd1 = r1; Rd2 = r2;
    #1;
    s_ar = a_ready; s_br = b_ready; s_rw = Rw; s_h1 = hazard1; s_h2 = hazard2;
    s_dir = Dir; s_din = DIn; s_cnt = wr_count;

    drain = m_full && !st;
    room  = !m_full || drain;
    ga    = room && av && (!bv || m_last_b);
    gb    = room && bv && (!av || !m_last_b);
    erw   = drain && (m_dir != 0);

    check("a_ready", s_ar, ga);
    check("b_ready", s_br, gb);
    check("rw", s_rw, erw);
    check("hazard1", s_h1, m_full && (m_dir == r1) && (r1 != 0));
    check("hazard2", s_h2, m_full && (m_dir == r2) && (r2 != 0));
    check("wr_count", s_cnt, m_cnt);
    if (erw) begin
      check("wr_dir", s_dir, m_dir);
      check("wr_data", s_din, m_data);
      m_cnt++;
    end

    if (ga || gb) begin
      m_full   = 1'b1;
      m_dir    = ga ? ad : bd;
      m_data   = ga ? adt : bdt;
      m_last_b = gb;
    end else if (drain) begin
      m_full = 1'b0;
    end
  endtask

  task automatic idle(input logic [DIRW-1:0] r1);
    step(0, '0, '0, 0, '0, '0, 0, r1, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    a_valid = 0; b_valid = 0; stall = 0;
    a_dir = '0; b_dir = '0; a_data = '0; b_data = '0; Rd1 = '0; Rd2 = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Quiet after reset.
    for (int i = 0; i < 10; i++) begin
      idle('0);
      check("idle_rw", s_rw, 1'b0);
      check("idle_dir", s_dir, 0);
      check("idle_din", s_din, 0);
      check("idle_cnt", s_cnt, 0);
    end

    // Both requesters valid: A,B,A,B, writes stream back to back.
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd3, 32'hA000 + i, 1, 5'd7, 32'hB000 + i, 0, '0, '0);
      check("ab_grant", {s_ar, s_br}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) begin
        check("ab_rw", s_rw, 1'b1);
        check("ab_dir", s_dir, ((i - 1) % 2 == 0) ? 3 : 7);
      end
    end
    idle('0);
    check("ab_last_rw", s_rw, 1'b1);
    check("ab_last_dir", s_dir, 7);
    idle('0);
    check("ab_cnt", s_cnt, 4);

    // A alone, one-cycle latency, hazard while pending.
    step(1, 5'd5, 32'h1234, 0, '0, '0, 0, '0, '0);
    check("a_only_ready", s_ar, 1'b1);
    idle(5'd5);
    check("a_only_rw", s_rw, 1'b1);
    check("a_only_dir", s_dir, 5);
    check("a_only_din", s_din, 32'h1234);
    check("a_only_haz", s_h1, 1'b1);
    idle('0);
    check("a_only_cnt", s_cnt, 5);

    // Stalled full slot freezes; release writes in the same cycle.
    step(1, 5'd9, 32'h9999, 0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd10, 32'hAAAA, 1, 5'd11, 32'hBBBB, 1, '0, '0);
      check("stall_ready", {s_ar, s_br}, 2'b00);
      check("stall_rw", s_rw, 1'b0);
      check("stall_dir", s_dir, 9);
    end
    step(1, 5'd10, 32'hAAAA, 1, 5'd11, 32'hBBBB, 0, '0, '0);
    check("unstall_rw", s_rw, 1'b1);
    check("unstall_dir", s_dir, 9);
    idle('0);
    idle('0);
    check("stall_cnt", s_cnt, 7);

    // Register 0 writes are consumed silently.
    step(1, 5'd0, 32'hDEAD, 0, '0, '0, 0, '0, '0);
    check("zero_ready", s_ar, 1'b1);
    idle(5'd0);
    check("zero_rw", s_rw, 1'b0);
    check("zero_haz", s_h1, 1'b0);
    idle('0);
    check("zero_cnt", s_cnt, 7);

    // Asynchronous reset with an entry pending discards it.
    step(1, 5'd12, 32'hC0C0, 0, '0, '0, 0, '0, '0);
    @(negedge clk);
    a_valid = 0; b_valid = 0; stall = 1; Rd1 = 5'd12; rst_n = 1'b0;
    #1;
    check("rst_rw", Rw, 1'b0);
    check("rst_dir", Dir, 0);
    check("rst_din", DIn, 0);
    check("rst_cnt", wr_count, 0);
    check("rst_haz", hazard1, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(5'd12);
      check("post_rst_rw", s_rw, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60, DIRW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 60, DIRW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0,
           DIRW'($urandom_range(0, 7)), DIRW'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
